// File: rtl/rv64_pkg.sv
// Shared RV64 writeback definitions: load-type encodings, writeback FIFO
// sizing and the buffered-load entry layout.
package rv64_pkg;

    localparam int XLEN       = 64;
    localparam int REG_W      = 5;
    localparam int NUM_REGS   = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    // Load funct3 encodings; 3'b111 is unused by RV64I loads.
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } ld_funct3_e;

    // One buffered load: destination register plus already-extended data.
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_entry_t;

    // One-hot decode of a register index, used to build the pending mask.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_W-1:0] rd);
        rd_onehot     = '0;
        rd_onehot[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback port bundle: ALU result, load response handshake and the
// register-file write / pending-load outputs.
interface wb_arbiter_if;
    import rv64_pkg::*;

    logic                alu_valid;
    logic [REG_W-1:0]    alu_rd;
    logic [XLEN-1:0]     alu_result;

    logic                ld_valid;
    logic                ld_ready;
    logic [REG_W-1:0]    ld_rd;
    logic [XLEN-1:0]     ld_data;
    logic [2:0]          ld_funct3;
    logic [2:0]          ld_offset;

    logic                regwrite;
    logic [REG_W-1:0]    write_reg;
    logic [XLEN-1:0]     write_data;
    logic [NUM_REGS-1:0] pending_mask;

    // Pipeline side: offers ALU results and load responses, sees the writes.
    modport master (
        output alu_valid, alu_rd, alu_result,
        output ld_valid, ld_rd, ld_data, ld_funct3, ld_offset,
        input  ld_ready,
        input  regwrite, write_reg, write_data, pending_mask
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  ld_valid, ld_rd, ld_data, ld_funct3, ld_offset,
        output ld_ready,
        output regwrite, write_reg, write_data, pending_mask
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order load writeback buffer. Entries are kept compacted at the low
// indices (index 0 is the head). Each cycle the head may be popped, any
// entry whose rd matches a younger ALU write may be squashed, and one new
// entry may be appended behind the survivors.
module wb_fifo
    import rv64_pkg::*;
(
    input  logic                  i_clock,
    input  logic                  i_reset,        // active-low, asynchronous
    input  logic                  i_push,
    input  wb_entry_t             i_push_entry,
    input  logic                  i_pop,
    input  logic                  i_squash,
    input  logic [REG_W-1:0]      i_squash_rd,
    output wb_entry_t             o_head,
    output logic                  o_empty,
    output logic [FIFO_CNT_W-1:0] o_count,
    output logic [NUM_REGS-1:0]   o_pending_mask
);

    logic [FIFO_DEPTH-1:0] r_valid;
    logic [FIFO_DEPTH-1:0] w_valid_nxt;
    logic [FIFO_DEPTH-1:0] w_keep;
    wb_entry_t             r_entry     [FIFO_DEPTH];
    wb_entry_t             w_entry_nxt [FIFO_DEPTH];

    // Decide which current entries survive this cycle's pop and squash.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_keep[i] = r_valid[i]
                      && !(i_pop && (i == 0))
                      && !(i_squash && (r_entry[i].rd == i_squash_rd));
        end
    end

    // Compact survivors toward the head, then append the incoming entry.
    always_comb begin
        int rank;
        // NOTE: every output of a combinational block gets a default first so no path can leave it unassigned and infer a latch.
        w_valid_nxt = '0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            w_entry_nxt[j] = r_entry[j];
        end
        rank = 0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_keep[i]) begin
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    if (rank == j) begin
                        w_entry_nxt[j] = r_entry[i];
                        w_valid_nxt[j] = 1'b1;
                    end
                end
                rank++;
            end
        end
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            if (i_push && (rank == j)) begin
                w_entry_nxt[j] = i_push_entry;
                w_valid_nxt[j] = 1'b1;
            end
        end
    end

    // Occupancy count and pending-register mask from the stored state.
    always_comb begin
        o_count        = '0;
        o_pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_valid[i]) begin
                o_count        = o_count + 1'b1;
                o_pending_mask = o_pending_mask | rd_onehot(r_entry[i].rd);
            end
        end
    end

    assign o_head  = r_entry[0];
    assign o_empty = !r_valid[0];

    // Valid bits: reset drops every buffered load at once.
    always_ff @(posedge i_clock or negedge i_reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!i_reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    // Entry payload storage.
    always_ff @(posedge i_clock) begin
        // NOTE: payload is not reset; it is never observed unless its valid bit is set, so resetting it would only add reset fan-out.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_entry[i] <= w_entry_nxt[i];
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter. ALU results always win the single write
// port; load responses are extracted/extended on acceptance and buffered in
// a small FIFO that drains whenever the ALU leaves the port free. An ALU
// write squashes older buffered loads to the same register.
module wb_arbiter
    import rv64_pkg::*;
(
    input  logic         i_clock,
    input  logic         i_reset,   // active-low, asynchronous
    wb_arbiter_if.slave  io_bus
);

    logic                  w_alu_issue;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ld_ready;
    logic                  w_fifo_empty;
    logic [FIFO_CNT_W-1:0] w_fifo_count;
    logic [NUM_REGS-1:0]   w_pending_mask;
    wb_entry_t             w_head;
    wb_entry_t             w_push_entry;
    logic [XLEN-1:0]       w_ld_shifted;
    logic [XLEN-1:0]       w_ld_ext;

    logic                  r_regwrite;
    logic [REG_W-1:0]      r_write_reg;
    logic [XLEN-1:0]       r_write_data;

    // Writes to x0 are architecturally dead, so they never claim the port.
    assign w_alu_issue = io_bus.alu_valid && (io_bus.alu_rd != '0);
    assign w_pop       = !w_alu_issue && !w_fifo_empty;

    // A full FIFO can still accept when its head drains in the same cycle.
    assign w_ld_ready = (w_fifo_count < FIFO_CNT_W'(FIFO_DEPTH))
                     || ((w_fifo_count == FIFO_CNT_W'(FIFO_DEPTH)) && w_pop);
    assign w_push     = io_bus.ld_valid && w_ld_ready && (io_bus.ld_rd != '0);

    // Move the addressed byte lane down to bit 0 before extension.
    assign w_ld_shifted = io_bus.ld_data >> {io_bus.ld_offset, 3'b000};

    // Size the loaded value and sign- or zero-extend it to XLEN.
    always_comb begin
        w_ld_ext = '0;
        case (ld_funct3_e'(io_bus.ld_funct3))
            F3_LB:   w_ld_ext = {{56{w_ld_shifted[7]}},  w_ld_shifted[7:0]};
            F3_LH:   w_ld_ext = {{48{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
            F3_LW:   w_ld_ext = {{32{w_ld_shifted[31]}}, w_ld_shifted[31:0]};
            F3_LD:   w_ld_ext = io_bus.ld_data;
            F3_LBU:  w_ld_ext = {56'd0, w_ld_shifted[7:0]};
            F3_LHU:  w_ld_ext = {48'd0, w_ld_shifted[15:0]};
            F3_LWU:  w_ld_ext = {32'd0, w_ld_shifted[31:0]};
            default: w_ld_ext = '0;
        endcase
    end

    assign w_push_entry = '{rd: io_bus.ld_rd, data: w_ld_ext};

    // The incoming load is appended after the squash, so a load accepted
    // alongside a same-rd ALU write survives (it is the younger producer).
    wb_fifo u_fifo (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_push         (w_push),
        .i_push_entry   (w_push_entry),
        .i_pop          (w_pop),
        .i_squash       (w_alu_issue),
        .i_squash_rd    (io_bus.alu_rd),
        .o_head         (w_head),
        .o_empty        (w_fifo_empty),
        .o_count        (w_fifo_count),
        .o_pending_mask (w_pending_mask)
    );

    // Register the winning write so it reaches the register file next cycle.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_regwrite   <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_regwrite <= w_alu_issue || w_pop;
            if (w_alu_issue) begin
                r_write_reg  <= io_bus.alu_rd;
                r_write_data <= io_bus.alu_result;
            end else if (w_pop) begin
                r_write_reg  <= w_head.rd;
                r_write_data <= w_head.data;
            end
        end
    end

    assign io_bus.ld_ready     = w_ld_ready;
    assign io_bus.regwrite     = r_regwrite;
    assign io_bus.write_reg    = r_write_reg;
    assign io_bus.write_data   = r_write_data;
    assign io_bus.pending_mask = w_pending_mask;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset state, load extension, ALU priority
// with back-pressure, squash rules, x0 handling and mid-run reset.
module tb_wb_arbiter;
    import rv64_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    wb_arbiter_if u_if ();

    wb_arbiter u_dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .io_bus  (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [63:0] res);
        u_if.alu_valid  = v;
        u_if.alu_rd     = rd;
        u_if.alu_result = res;
    endtask

    task automatic drive_ld(input logic v, input logic [2:0] f3, input logic [2:0] off,
                            input logic [4:0] rd, input logic [63:0] data);
        u_if.ld_valid  = v;
        u_if.ld_funct3 = f3;
        u_if.ld_offset = off;
        u_if.ld_rd     = rd;
        u_if.ld_data   = data;
    endtask

    task automatic check_wr(input string tag, input logic [4:0] rd, input logic [63:0] data);
        check({tag, ".regwrite"},   64'(u_if.regwrite),   64'd1);
        check({tag, ".write_reg"},  64'(u_if.write_reg),  64'(rd));
        check({tag, ".write_data"}, u_if.write_data,      data);
    endtask

    // Single load with no ALU traffic: offer, buffer, write two cycles later.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [2:0] off,
                            input logic [4:0] rd, input logic [63:0] data, input logic [63:0] exp);
        drive_ld(1'b1, f3, off, rd, data);
        settle();
        check({tag, ".ready"}, 64'(u_if.ld_ready), 64'd1);
        tick();
        drive_ld(1'b0, 3'd0, 3'd0, 5'd0, 64'd0);
        settle();
        check({tag, ".pending"},  64'(u_if.pending_mask), 64'd1 << rd);
        check({tag, ".idle_wr"},  64'(u_if.regwrite),     64'd0);
        tick();
        settle();
        check_wr(tag, rd, exp);
        check({tag, ".pending_clr"}, 64'(u_if.pending_mask), 64'd0);
        tick();
        settle();
        check({tag, ".after"}, 64'(u_if.regwrite), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_alu(1'b0, 5'd0, 64'd0);
        drive_ld(1'b0, 3'd0, 3'd0, 5'd0, 64'd0);

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #2;
        check("rst.regwrite",   64'(u_if.regwrite),     64'd0);
        check("rst.write_reg",  64'(u_if.write_reg),    64'd0);
        check("rst.write_data", u_if.write_data,        64'd0);
        check("rst.pending",    64'(u_if.pending_mask), 64'd0);
        tick();
        rst_n = 1'b1;
        settle();
        check("rst.ld_ready", 64'(u_if.ld_ready), 64'd1);
        tick();

        // ---- extension vectors ----
        run_load("lb",  F3_LB,  3'd1, 5'd5,  64'h0000_0000_0000_8000, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("lwu", F3_LWU, 3'd4, 5'd7,  64'hDEAD_BEEF_8000_0001, 64'h0000_0000_DEAD_BEEF);
        run_load("lh",  F3_LH,  3'd6, 5'd9,  64'h8123_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8123);
        run_load("lw",  F3_LW,  3'd0, 5'd10, 64'hDEAD_BEEF_8000_0001, 64'hFFFF_FFFF_8000_0001);
        run_load("lbu", F3_LBU, 3'd2, 5'd11, 64'h0000_0000_00F0_0000, 64'h0000_0000_0000_00F0);
        run_load("lhu", F3_LHU, 3'd4, 5'd12, 64'h0000_FEDC_0000_0000, 64'h0000_0000_0000_FEDC);
        run_load("ld",  F3_LD,  3'd3, 5'd13, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

        // ---- ALU priority, back-pressure, push+pop when full ----
        drive_alu(1'b1, 5'd3, 64'hA1);
        drive_ld(1'b1, F3_LD, 3'd0, 5'd8, 64'h8);
        settle();
        check("bp.c0.ready", 64'(u_if.ld_ready), 64'd1);
        tick();
        drive_ld(1'b1, F3_LD, 3'd0, 5'd9, 64'h9);
        settle();
        check("bp.c1.ready", 64'(u_if.ld_ready), 64'd1);
        check_wr("bp.c1", 5'd3, 64'hA1);
        check("bp.c1.pending", 64'(u_if.pending_mask), 64'h100);
        tick();
        drive_ld(1'b1, F3_LD, 3'd0, 5'd10, 64'hA);
        settle();
        check("bp.c2.ready",   64'(u_if.ld_ready),     64'd0);
        check("bp.c2.pending", 64'(u_if.pending_mask), 64'h300);
        tick();
        settle();
        check("bp.c3.ready",   64'(u_if.ld_ready),     64'd0);
        check("bp.c3.pending", 64'(u_if.pending_mask), 64'h300);
        check_wr("bp.c3", 5'd3, 64'hA1);
        tick();
        drive_alu(1'b0, 5'd0, 64'd0);
        settle();
        check("bp.c4.ready_full_pop", 64'(u_if.ld_ready), 64'd1);
        tick();
        drive_ld(1'b0, 3'd0, 3'd0, 5'd0, 64'd0);
        settle();
        check_wr("bp.w8", 5'd8, 64'h8);
        check("bp.c5.pending", 64'(u_if.pending_mask), 64'h600);
        tick();
        settle();
        check_wr("bp.w9", 5'd9, 64'h9);
        check("bp.c6.pending", 64'(u_if.pending_mask), 64'h400);
        tick();
        settle();
        check_wr("bp.w10", 5'd10, 64'hA);
        check("bp.c7.pending", 64'(u_if.pending_mask), 64'd0);
        tick();
        settle();
        check("bp.c8.idle", 64'(u_if.regwrite), 64'd0);

        // ---- buffered load squashed by a younger ALU write ----
        drive_ld(1'b1, F3_LD, 3'd0, 5'd4, 64'hAA);
        tick();
        drive_ld(1'b0, 3'd0, 3'd0, 5'd0, 64'd0);
        drive_alu(1'b1, 5'd4, 64'h11);
        settle();
        check("sq.pending_set", 64'(u_if.pending_mask), 64'h10);
        tick();
        drive_alu(1'b0, 5'd0, 64'd0);
        settle();
        check("sq.pending_clr", 64'(u_if.pending_mask), 64'd0);
        check_wr("sq.alu", 5'd4, 64'h11);
        tick();
        settle();
        check("sq.no_load_wr1", 64'(u_if.regwrite), 64'd0);
        tick();
        settle();
        check("sq.no_load_wr2", 64'(u_if.regwrite), 64'd0);

        // ---- load accepted alongside same-rd ALU write is not squashed ----
        drive_alu(1'b1, 5'd6, 64'h66);
        drive_ld(1'b1, F3_LD, 3'd0, 5'd6, 64'h77);
        settle();
        check("young.ready", 64'(u_if.ld_ready), 64'd1);
        tick();
        drive_alu(1'b0, 5'd0, 64'd0);
        drive_ld(1'b0, 3'd0, 3'd0, 5'd0, 64'd0);
        settle();
        check_wr("young.alu", 5'd6, 64'h66);
        check("young.pending", 64'(u_if.pending_mask), 64'h40);
        tick();
        settle();
        check_wr("young.load", 5'd6, 64'h77);
        check("young.pending_clr", 64'(u_if.pending_mask), 64'd0);
        tick();
        settle();
        check("young.idle", 64'(u_if.regwrite), 64'd0);

        // ---- ALU to x0 frees the port for a FIFO pop ----
        drive_ld(1'b1, F3_LD, 3'd0, 5'd12, 64'hC);
        tick();
        drive_ld(1'b0, 3'd0, 3'd0, 5'd0, 64'd0);
        drive_alu(1'b1, 5'd0, 64'h99);
        settle();
        check("x0alu.pending", 64'(u_if.pending_mask), 64'h1000);
        tick();
        drive_alu(1'b0, 5'd0, 64'd0);
        settle();
        check_wr("x0alu.pop", 5'd12, 64'hC);
        tick();

        // ---- load and ALU both to x0: nothing written, nothing pending ----
        drive_alu(1'b1, 5'd0, 64'h55);
        drive_ld(1'b1, F3_LD, 3'd0, 5'd0, 64'h66);
        settle();
        check("x0.ready", 64'(u_if.ld_ready), 64'd1);
        tick();
        drive_alu(1'b0, 5'd0, 64'd0);
        drive_ld(1'b0, 3'd0, 3'd0, 5'd0, 64'd0);
        settle();
        check("x0.regwrite1", 64'(u_if.regwrite),     64'd0);
        check("x0.pending",   64'(u_if.pending_mask), 64'd0);
        tick();
        settle();
        check("x0.regwrite2", 64'(u_if.regwrite), 64'd0);

        // ---- reset pulse with two loads buffered ----
        drive_alu(1'b1, 5'd3, 64'hB0);
        drive_ld(1'b1, F3_LD, 3'd0, 5'd13, 64'hD);
        tick();
        drive_ld(1'b1, F3_LD, 3'd0, 5'd14, 64'hE);
        tick();
        drive_ld(1'b0, 3'd0, 3'd0, 5'd0, 64'd0);
        settle();
        check("mr.pending_pre",  64'(u_if.pending_mask), 64'h6000);
        check("mr.regwrite_pre", 64'(u_if.regwrite),     64'd1);
        rst_n = 1'b0;
        drive_alu(1'b0, 5'd0, 64'd0);
        settle();
        check("mr.regwrite_in",   64'(u_if.regwrite),     64'd0);
        check("mr.pending_in",    64'(u_if.pending_mask), 64'd0);
        check("mr.write_data_in", u_if.write_data,        64'd0);
        tick();
        rst_n = 1'b1;
        settle();
        check("mr.regwrite_rel", 64'(u_if.regwrite),     64'd0);
        check("mr.pending_rel",  64'(u_if.pending_mask), 64'd0);
        tick();
        settle();
        check("mr.no_wr1", 64'(u_if.regwrite), 64'd0);
        tick();
        settle();
        check("mr.no_wr2", 64'(u_if.regwrite), 64'd0);
        tick();
        settle();
        check("mr.no_wr3", 64'(u_if.regwrite), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 clock  in  1  single clock, all state updates on posedge clock.
REQ-002 reset  in  1  asynchronous, active-low reset; asserted when 0.
REQ-003 alu_valid  in  1  ALU result present this cycle; cannot be stalled.
REQ-004 alu_rd  in  5  ALU destination register.
REQ-005 alu_result  in  64  ALU result.
REQ-006 ld_valid  in  1  load response offered this cycle.
REQ-007 ld_ready  out  1  load response accepted when ld_valid && ld_ready.
REQ-008 ld_rd  in  5  load destination register.
REQ-009 ld_data  in  64  raw aligned doubleword from data memory.
REQ-010 ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
REQ-011 ld_offset  in  3  byte offset of the access within the doubleword.
REQ-012 regwrite  out  1  register-file write enable (registered).
REQ-013 write_reg  out  5  register-file write address (registered).
REQ-014 write_data  out  64  register-file write data (registered).
REQ-015 pending_mask  out  32  bit i set while a buffered load targets register i.

Function
REQ-016 The block SHALL extract the byte/half/word/doubleword at ld_offset from ld_data, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) it to 64 bits; LD passes through.
REQ-017 Extension SHALL occur at acceptance; the FIFO stores {rd, extended data}.
REQ-018 Accepted loads SHALL enter a 2-entry in-order FIFO; ld_ready = (count < 2), or (count == 2 and a pop occurs this cycle).
REQ-019 Accepted loads with ld_rd == 0 SHALL be discarded without entering the FIFO.
REQ-020 Arbitration each cycle: if alu_valid && alu_rd != 0, the ALU write SHALL be issued; otherwise, if the FIFO is non-empty, the head SHALL be popped and issued; otherwise nothing is issued.
REQ-021 An issued write SHALL appear on regwrite/write_reg/write_data exactly one cycle after the arbitration cycle; regwrite SHALL be 0 otherwise.
REQ-022 alu_valid with alu_rd == 0 SHALL issue nothing and SHALL free the slot for a FIFO pop.
REQ-023 When an ALU write is issued, any FIFO entry with a matching rd SHALL be squashed (ALU is younger in program order); squashed entries are removed without issue.
REQ-024 A load accepted in the same cycle as an issued ALU write with matching rd SHALL NOT be squashed (the load is younger).
REQ-025 Push and pop in the same cycle SHALL be supported at any count, including full.
REQ-026 Minimum load latency SHALL be 2 cycles, from acceptance edge to regwrite high.
REQ-027 pending_mask SHALL be the OR of one-hot(rd) over valid FIFO entries, updated in the cycle the FIFO changes.

Reset
REQ-028 While reset = 0: FIFO empty, pending_mask = 0, regwrite = 0, write_reg = 0, write_data = 0, ld_ready = 1 after release.
REQ-029 Reset asserted mid-operation SHALL drop all buffered loads immediately; no partial write SHALL be issued.

Structure
REQ-030 The load funct3 encodings and FIFO depth constant (2) SHALL be placed in a shared package, rv64_pkg.
REQ-031 The FIFO with per-entry squash-by-rd SHALL be a sub-module, wb_fifo; extension and arbitration stay in wb_arbiter.

Verification
REQ-032 LB, ld_data = 64'h0000_0000_0000_8000, ld_offset = 1, rd = 5, no ALU -> two cycles later, regwrite = 1, write_reg = 5, write_data = 64'hFFFF_FFFF_FFFF_FF80.
REQ-033 LWU, ld_data = 64'hDEAD_BEEF_8000_0001, ld_offset = 4, rd = 7 -> write_data = 64'h0000_0000_DEAD_BEEF.
REQ-034 alu_valid held for 4 cycles (rd = 3) while loads to rd 8, 9, 10 are offered -> loads 8 and 9 accepted, ld_ready = 0 for load 10, pending_mask = 0x300; after the ALU stops, writes occur in order 8, 9, 10.
REQ-035 Load to rd 4 buffered, then ALU write to rd 4 with value 0x11 -> pending_mask bit 4 clears; only 0x11 is written to register 4.
REQ-036 Load to rd 0 plus ALU write to rd 0 -> regwrite stays 0 and pending_mask = 0.
REQ-037 Two loads buffered, reset pulsed low for 1 cycle -> regwrite = 0, pending_mask = 0, no write of the buffered data afterwards.
